// File: rtl/card_deal_scheduler.sv
// -----------------------------------------------------------------------------
// card_deal_scheduler
//
// Owns the 52-card shoe for the blackjack game. A used-card bitmap guarantees
// that no card is dealt twice until start_deal reshuffles. After start_deal the
// opening deal (P, D, P, D) runs by itself. After that, hit requests from the
// player and dealer hand logic are served, alternating when both are pending.
//
// Card index idx is 0..51: suit = idx / 13 and rank = idx % 13 + 1. The rank
// and suit decode assumes a standard 4 x 13 deck.
//
// Ports
//   CLOCK_50       in   system clock, all logic on posedge
//   reset          in   asynchronous active-high reset
//   start_deal     in   pulse: reshuffle and run the opening deal (IDLE/SERVE only)
//   req_player     in   level: player wants one card, held until granted
//   req_dealer     in   level: dealer wants one card, held until granted
//   rand_in[5:0]   in   random start index, sampled when a draw starts
//   card_valid     out  pulse: card_* valid this cycle
//   card_to_dealer out  destination of the card (0 = player, 1 = dealer)
//   card_rank[3:0] out  1..13
//   card_suit[1:0] out  0..3
//   card_value[3:0]out  A = 1, 2..10 face value, J/Q/K = 10
//   cards_left[5:0]out  undealt cards
//   deck_empty     out  cards_left == 0
//   busy           out  high in CLEAR, INIT, SEARCH, ISSUE
//   init_done      out  pulse when the opening deal completes
// -----------------------------------------------------------------------------
module card_deal_scheduler #(
  parameter int DECK_SIZE  = 52,
  parameter int INIT_CARDS = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start_deal,
  input  logic       req_player,
  input  logic       req_dealer,
  input  logic [5:0] rand_in,
  output logic       card_valid,
  output logic       card_to_dealer,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [3:0] card_value,
  output logic [5:0] cards_left,
  output logic       deck_empty,
  output logic       busy,
  output logic       init_done
);

  localparam logic [5:0] LP_DECK = 6'(DECK_SIZE);
  localparam logic [2:0] LP_INIT = 3'(INIT_CARDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_INIT,
    S_SEARCH,
    S_ISSUE,
    S_SERVE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DECK_SIZE-1:0] r_used;
  logic [DECK_SIZE-1:0] w_set_mask;
  logic [5:0]           r_cards_left;
  logic [5:0]           r_idx;
  logic [2:0]           r_init_cnt;
  logic                 r_init_phase;
  logic                 r_dest;
  logic                 r_last_grant;
  logic [3:0]           r_card_rank;
  logic [1:0]           r_card_suit;
  logic [3:0]           r_card_value;
  logic                 r_card_to_dealer;

  logic                 w_deck_empty;
  logic                 w_any_req;
  logic                 w_grant_dealer;
  logic                 w_init_finished;
  logic                 w_start_draw;
  logic                 w_start_dest;
  logic [5:0]           w_first_idx;
  logic [5:0]           w_next_idx;
  logic                 w_cand_used;
  logic [1:0]           w_suit;
  logic [5:0]           w_suit_base;
  logic [3:0]           w_rank;
  logic [3:0]           w_value;

  // ---------------------------------------------------------------------------
  // Draw control
  // ---------------------------------------------------------------------------
  assign w_deck_empty    = (r_cards_left == 6'd0);
  assign w_any_req       = req_player | req_dealer;
  // With both requests pending, serve whoever did not get the previous card.
  assign w_grant_dealer  = (req_player & req_dealer) ? ~r_last_grant : req_dealer;
  assign w_init_finished = (r_init_cnt == LP_INIT);

  assign w_start_draw = ((r_state == S_INIT) && !w_init_finished) ||
                        ((r_state == S_SERVE) && !start_deal && !w_deck_empty && w_any_req);
  assign w_start_dest = (r_state == S_INIT) ? r_init_cnt[0] : w_grant_dealer;

  // rand_in covers 0..63; fold 52..63 back onto 0..11.
  assign w_first_idx = (rand_in < LP_DECK) ? rand_in : (rand_in - LP_DECK);
  assign w_next_idx  = (r_idx == LP_DECK - 6'd1) ? 6'd0 : (r_idx + 6'd1);
  assign w_cand_used = r_used[r_idx];

  // One-hot mask of the card being issued.
  for (genvar gi = 0; gi < DECK_SIZE; gi++) begin : g_set_mask
    assign w_set_mask[gi] = (r_idx == 6'(gi));
  end

  // Rank/suit decode of the current candidate.
  always_comb begin
    w_suit      = 2'd0;
    w_suit_base = 6'd0;
    if (r_idx >= 6'd39) begin
      w_suit      = 2'd3;
      w_suit_base = 6'd39;
    end else if (r_idx >= 6'd26) begin
      w_suit      = 2'd2;
      w_suit_base = 6'd26;
    end else if (r_idx >= 6'd13) begin
      w_suit      = 2'd1;
      w_suit_base = 6'd13;
    end
    w_rank  = 4'(r_idx - w_suit_base + 6'd1);
    w_value = (w_rank > 4'd10) ? 4'd10 : w_rank;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start_deal) w_state_next = S_CLEAR;
      S_CLEAR:  w_state_next = S_INIT;
      S_INIT:   w_state_next = w_init_finished ? S_SERVE : S_SEARCH;
      S_SEARCH: if (!w_cand_used) w_state_next = S_ISSUE;
      S_ISSUE:  w_state_next = r_init_phase ? S_INIT : S_SERVE;
      S_SERVE: begin
        if (start_deal)        w_state_next = S_CLEAR;
        else if (w_start_draw) w_state_next = S_SEARCH;
      end
      default:  w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    card_valid = (r_state == S_ISSUE);
    busy       = (r_state == S_CLEAR) || (r_state == S_INIT) ||
                 (r_state == S_SEARCH) || (r_state == S_ISSUE);
    init_done  = (r_state == S_INIT) && w_init_finished;
  end

  // ---------------------------------------------------------------------------
  // Shoe bookkeeping and card registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_used           <= '0;
      r_cards_left     <= LP_DECK;
      r_idx            <= 6'd0;
      r_init_cnt       <= 3'd0;
      r_init_phase     <= 1'b0;
      r_dest           <= 1'b0;
      r_last_grant     <= 1'b1;
      r_card_rank      <= 4'd0;
      r_card_suit      <= 2'd0;
      r_card_value     <= 4'd0;
      r_card_to_dealer <= 1'b0;
    end else begin
      if (w_start_draw) begin
        r_idx  <= w_first_idx;
        r_dest <= w_start_dest;
      end
      case (r_state)
        S_CLEAR: begin
          r_used       <= '0;
          r_cards_left <= LP_DECK;
          r_init_cnt   <= 3'd0;
          r_init_phase <= 1'b1;
        end
        S_INIT: begin
          if (w_init_finished) r_init_phase <= 1'b0;
        end
        S_SEARCH: begin
          if (w_cand_used) begin
            r_idx <= w_next_idx;
          end else begin
            // Card outputs change only when a new card is issued and then hold.
            r_card_rank      <= w_rank;
            r_card_suit      <= w_suit;
            r_card_value     <= w_value;
            r_card_to_dealer <= r_dest;
          end
        end
        S_ISSUE: begin
          r_used       <= r_used | w_set_mask;
          r_cards_left <= r_cards_left - 6'd1;
          r_last_grant <= r_dest;
          if (r_init_phase) r_init_cnt <= r_init_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign card_to_dealer = r_card_to_dealer;
  assign card_rank      = r_card_rank;
  assign card_suit      = r_card_suit;
  assign card_value     = r_card_value;
  assign cards_left     = r_cards_left;
  assign deck_empty     = w_deck_empty;

endmodule

// File: tb/tb_card_deal_scheduler.sv
// Directed bench for card_deal_scheduler. Expected cards come from an
// independent shoe model and are queued when a draw is requested; a monitor
// pops and compares them on every card_valid pulse.
module tb_card_deal_scheduler;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       start_deal;
  logic       req_player;
  logic       req_dealer;
  logic [5:0] rand_in;
  logic       card_valid;
  logic       card_to_dealer;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic [3:0] card_value;
  logic [5:0] cards_left;
  logic       deck_empty;
  logic       busy;
  logic       init_done;

  always #5 CLOCK_50 = ~CLOCK_50;

  card_deal_scheduler dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .start_deal    (start_deal),
    .req_player    (req_player),
    .req_dealer    (req_dealer),
    .rand_in       (rand_in),
    .card_valid    (card_valid),
    .card_to_dealer(card_to_dealer),
    .card_rank     (card_rank),
    .card_suit     (card_suit),
    .card_value    (card_value),
    .cards_left    (cards_left),
    .deck_empty    (deck_empty),
    .busy          (busy),
    .init_done     (init_done)
  );

  typedef struct {
    logic       dealer;
    logic [3:0] rank;
    logic [1:0] suit;
    logic [3:0] value;
  } card_t;

  card_t exp_q[$];
  bit    model_used[52];
  int    model_left;
  int    errors = 0;
  int    checks = 0;
  int    cards_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 52; i++) model_used[i] = 1'b0;
    model_left = 52;
  endtask

  // Predict the card for a draw starting at rnd and queue it.
  task automatic expect_card(input int rnd, input bit dealer, output int probes);
    int    idx;
    int    rank;
    card_t c;
    idx    = rnd % 52;
    probes = 0;
    while (model_used[idx]) begin
      idx    = (idx + 1) % 52;
      probes = probes + 1;
    end
    model_used[idx] = 1'b1;
    model_left      = model_left - 1;
    rank    = idx % 13 + 1;
    c.dealer = dealer;
    c.rank   = 4'(rank);
    c.suit   = 2'(idx / 13);
    c.value  = (rank > 10) ? 4'd10 : 4'(rank);
    exp_q.push_back(c);
  endtask

  // Monitor: every card_valid pulse must match the head of the scoreboard.
  always @(negedge CLOCK_50) begin
    if (!reset && card_valid) begin
      card_t c;
      cards_seen++;
      check("card_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        c = exp_q.pop_front();
        check("card_dest",  32'(card_to_dealer), 32'(c.dealer));
        check("card_rank",  32'(card_rank),      32'(c.rank));
        check("card_suit",  32'(card_suit),      32'(c.suit));
        check("card_value", 32'(card_value),     32'(c.value));
      end
      $display("card #%0d: dest=%0d rank=%0d suit=%0d value=%0d", cards_seen,
               card_to_dealer, card_rank, card_suit, card_value);
    end
  end

  // Count cycles until card_valid, bounded.
  task automatic wait_valid(input string tag, input int limit, output int n);
    bit got;
    got = 1'b0;
    n   = 0;
    while (!got && n < limit) begin
      @(negedge CLOCK_50);
      if (card_valid) got = 1'b1;
      else            n = n + 1;
    end
    if (!got) check({tag, "_valid_seen"}, 32'(got), 32'd1);
  endtask

  // Entered at posedge+1 with the DUT in IDLE or SERVE.
  task automatic opening(input int rnd);
    int probes;
    int n;
    bit got;
    model_reset();
    rand_in = 6'(rnd);
    for (int i = 0; i < 4; i++) expect_card(rnd, i[0], probes);
    start_deal = 1'b1;
    @(posedge CLOCK_50); #1;
    start_deal = 1'b0;
    got = 1'b0;
    n   = 0;
    while (!got && n < 400) begin
      @(negedge CLOCK_50);
      if (init_done) got = 1'b1;
      n = n + 1;
    end
    check("init_done_seen", 32'(got), 32'd1);
    check("init_cards_left", 32'(cards_left), 32'd48);
    check("init_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("opening deal rnd=%0d: cards_left=%0d", rnd, cards_left);
    @(posedge CLOCK_50); #1;
  endtask

  // Single hit for one requester; entered at posedge+1 in SERVE.
  task automatic serve_draw(input string tag, input bit dealer, input int rnd);
    int probes;
    int n;
    rand_in = 6'(rnd);
    expect_card(rnd, dealer, probes);
    if (dealer) req_dealer = 1'b1;
    else        req_player = 1'b1;
    wait_valid(tag, 80, n);
    check({tag, "_latency"}, 32'(n), 32'(2 + probes));
    @(posedge CLOCK_50); #1;
    req_dealer = 1'b0;
    req_player = 1'b0;
    @(posedge CLOCK_50); #1;
  endtask

  initial begin
    int n;
    int probes;
    int seen;
    reset      = 1'b1;
    start_deal = 1'b0;
    req_player = 1'b0;
    req_dealer = 1'b0;
    rand_in    = 6'd0;
    model_reset();

    // Reset state
    repeat (2) @(posedge CLOCK_50);
    #1 reset = 1'b0;
    @(negedge CLOCK_50);
    check("rst_card_valid", 32'(card_valid), 32'd0);
    check("rst_cards_left", 32'(cards_left), 32'd52);
    check("rst_deck_empty", 32'(deck_empty), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_init_done",  32'(init_done),  32'd0);
    check("rst_card_rank",  32'(card_rank),  32'd0);
    check("rst_card_dest",  32'(card_to_dealer), 32'd0);

    // Requests in IDLE are ignored
    @(posedge CLOCK_50); #1;
    req_player = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    check("idle_req_busy", 32'(busy), 32'd0);
    @(posedge CLOCK_50); #1;
    req_player = 1'b0;

    // 1. Opening deal from rand_in = 0: P r1, D r2, P r3, D r4
    opening(0);
    check("hold_card_rank", 32'(card_rank), 32'd4);
    check("hold_card_dest", 32'(card_to_dealer), 32'd1);
    check("serve_busy", 32'(busy), 32'd0);

    // 2. rand_in = 60 folds to idx 8: rank 9, value 9, latency 2
    serve_draw("t2", 1'b0, 60);

    // 3. Reshuffle from SERVE; draw idx 51, then wrap from 51 to idx 0
    opening(1);
    serve_draw("t3_k", 1'b1, 51);
    serve_draw("t3_wrap", 1'b1, 51);

    // 4. Both requests held: P, D, P
    rand_in = 6'd20;
    expect_card(20, 1'b0, probes);
    expect_card(20, 1'b1, probes);
    expect_card(20, 1'b0, probes);
    req_player = 1'b1;
    req_dealer = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid("t4", 80, n);
      check("t4_alternate", 32'(card_to_dealer), 32'(k % 2));
    end
    @(posedge CLOCK_50); #1;
    req_player = 1'b0;
    req_dealer = 1'b0;
    @(posedge CLOCK_50); #1;
    check("t4_queue_drained", 32'(exp_q.size()), 32'd0);

    // 5. Empty the shoe, then requests must go unanswered
    for (int k = 0; model_left > 0 && k < 60; k++)
      serve_draw("t5_drain", k[0], int'($urandom_range(0, 63)));
    @(negedge CLOCK_50);
    check("t5_cards_left", 32'(cards_left), 32'd0);
    check("t5_deck_empty", 32'(deck_empty), 32'd1);
    @(posedge CLOCK_50); #1;
    req_player = 1'b1;
    seen = 0;
    repeat (100) begin
      @(negedge CLOCK_50);
      if (card_valid) seen++;
    end
    check("t5_no_card_when_empty", 32'(seen), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    @(posedge CLOCK_50); #1;
    req_player = 1'b0;

    // 6. Reset during SEARCH of the first opening draw
    rand_in    = 6'd10;
    start_deal = 1'b1;
    @(posedge CLOCK_50); #1;   // CLEAR
    start_deal = 1'b0;
    @(posedge CLOCK_50);       // INIT
    @(posedge CLOCK_50); #2;   // SEARCH
    check("t6_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_card_valid", 32'(card_valid), 32'd0);
    check("t6_cards_left", 32'(cards_left), 32'd52);
    check("t6_busy_after", 32'(busy), 32'd0);
    @(posedge CLOCK_50);
    @(posedge CLOCK_50); #1;
    reset = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    #1;
    opening(5);

    // last_grant is dealer after the opening deal: both held -> P first
    rand_in = 6'd30;
    expect_card(30, 1'b0, probes);
    expect_card(30, 1'b1, probes);
    req_player = 1'b1;
    req_dealer = 1'b1;
    for (int k = 0; k < 2; k++) wait_valid("t6_alt", 80, n);
    @(posedge CLOCK_50); #1;
    req_player = 1'b0;
    req_dealer = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    check("final_queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_cards_left", 32'(cards_left), 32'd46);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
